rgb_pwm_ctrl: RTL and testbench

RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

---
 rtl/rgb_pwm_ctrl_if.sv | 11 +
 rtl/rgb_pwm_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_ctrl_if.sv
// Register write bus for rgb_pwm_ctrl: one write per cycle while wr_en is high.
interface rgb_pwm_ctrl_if #(
  parameter int PWM_W = 8
);
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [PWM_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel RGB LED PWM controller with shadowed duty/control registers
// and four lighting modes (direct, breathe, blink, test). Every register
// update becomes visible only at a PWM period boundary, so no period is
// ever cut short or stretched by a write.
module rgb_pwm_ctrl #(
  parameter int N_CH      = 3,
  parameter int PWM_W     = 8,
  parameter int PRESC_DIV = 16,
  parameter int STEP_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  rgb_pwm_ctrl_if.slave       bus,
  output logic [N_CH-1:0]     pwm,
  output logic                period_start,
  output logic [1:0]          mode_o
);

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_TEST    = 2'd3
  } mode_t;

  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int STEP_W  = (STEP_LOG2 > 0) ? STEP_LOG2 : 1;
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PWM_W-1:0]   DUTY_MAX  = '1;
  localparam logic [PWM_W-1:0]   LEVEL_TOP = DUTY_MAX - 1'b1;
  localparam logic [PRESC_W-1:0] PRESC_END = PRESC_W'(PRESC_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_CH - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PWM_W-1:0]   cnt_q;
  logic               tick;
  logic               wrap;
  logic               period_start_q;

  logic [PWM_W-1:0]   shadow_duty [N_CH];
  logic [PWM_W-1:0]   active_duty [N_CH];
  mode_t              shadow_mode;
  logic               shadow_en;
  logic               active_en;

  mode_t              mode_q, mode_d;
  logic [PWM_W-1:0]   level_q, level_d;
  logic               dir_down_q, dir_down_d;
  logic               phase_on_q, phase_on_d;
  logic [IDX_W-1:0]   test_idx_q, test_idx_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               step_wrap;

  logic [N_CH-1:0]    pwm_d;
  logic [N_CH-1:0]    pwm_q;

  assign tick      = (presc_q == PRESC_END);
  assign wrap      = tick && (cnt_q == DUTY_MAX);
  assign step_wrap = (STEP_LOG2 == 0) || (step_q == '1);

  // Prescaler and PWM counter: cnt advances once per tick and wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= tick ? '0 : presc_q + 1'b1;
      cnt_q          <= tick ? cnt_q + 1'b1 : cnt_q;
      period_start_q <= wrap;
    end
  end

  // Shadow registers take bus writes at any time; unknown addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) shadow_duty[i] <= '0;
      shadow_mode <= MODE_DIRECT;
      shadow_en   <= 1'b0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.wr_addr == 4'(i)) shadow_duty[i] <= bus.wr_data;
      end
      if (bus.wr_addr == 4'hF) begin
        shadow_mode <= mode_t'(bus.wr_data[1:0]);
        shadow_en   <= bus.wr_data[2];
      end
    end
  end

  // Active duty/enable are refreshed only as the counter wraps into a new period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) active_duty[i] <= '0;
      active_en <= 1'b0;
    end else if (wrap) begin
      active_duty <= shadow_duty;
      active_en   <= shadow_en;
    end
  end

  // Mode state and per-mode sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_DIRECT;
      level_q    <= '0;
      dir_down_q <= 1'b0;
      phase_on_q <= 1'b1;
      test_idx_q <= '0;
      step_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
      phase_on_q <= phase_on_d;
      test_idx_q <= test_idx_d;
      step_q     <= step_d;
    end
  end

  // Next mode and sequencing state; everything moves only at a period boundary.
  always_comb begin
    mode_d     = mode_q;
    level_d    = level_q;
    dir_down_d = dir_down_q;
    phase_on_d = phase_on_q;
    test_idx_d = test_idx_q;
    step_d     = step_q;
    if (wrap) begin
      mode_d = shadow_mode;
      if (shadow_mode != mode_q) begin
        level_d    = '0;
        dir_down_d = 1'b0;
        phase_on_d = 1'b1;
        test_idx_d = '0;
        step_d     = '0;
      end else begin
        case (mode_q)
          MODE_BREATHE: begin
            if (!dir_down_q) begin
              level_d = level_q + 1'b1;
              if (level_q == LEVEL_TOP) dir_down_d = 1'b1;
            end else begin
              level_d = level_q - 1'b1;
              if (level_q == PWM_W'(1)) dir_down_d = 1'b0;
            end
          end
          MODE_BLINK: begin
            step_d = step_q + 1'b1;
            if (step_wrap) phase_on_d = !phase_on_q;
          end
          MODE_TEST: begin
            step_d = step_q + 1'b1;
            if (step_wrap) test_idx_d = (test_idx_q == IDX_LAST) ? '0 : test_idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-channel effective duty and compare against the running counter.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [2*PWM_W-1:0] product;
    logic [PWM_W-1:0]   duty_eff;

    assign product = {{PWM_W{1'b0}}, active_duty[g]} * {{PWM_W{1'b0}}, level_q};

    // Select the duty this channel actually uses in the current mode.
    always_comb begin
      duty_eff = active_duty[g];
      case (mode_q)
        MODE_BREATHE: duty_eff = product[2*PWM_W-1:PWM_W];
        MODE_BLINK:   duty_eff = phase_on_q ? active_duty[g] : '0;
        MODE_TEST:    duty_eff = (test_idx_q == IDX_W'(g)) ? DUTY_MAX : '0;
        default:      duty_eff = active_duty[g];
      endcase
    end

    assign pwm_d[g] = active_en && (cnt_q < duty_eff);
  end

  // Registered PWM outputs, one clock behind the counter value they encode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end

  assign pwm          = pwm_q;
  assign period_start = period_start_q;
  assign mode_o       = mode_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl. A period-level reference model
// (shadow/active registers, periods-since-mode-entry arithmetic for the
// breathe triangle, blink phase and test index) predicts every PWM sample;
// each completed period is scored for high time, waveform shape,
// period_start placement and mode_o.
module tb_rgb_pwm_ctrl;
  localparam int N_CH      = 3;
  localparam int PWM_W     = 8;
  localparam int PRESC_DIV = 1;
  localparam int STEP_LOG2 = 2;
  localparam int PER       = 1 << PWM_W;
  localparam int MAXV      = PER - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] pwm;
  logic            period_start;
  logic [1:0]      mode_o;

  rgb_pwm_ctrl_if #(.PWM_W(PWM_W)) bus ();

  rgb_pwm_ctrl #(
    .N_CH(N_CH), .PWM_W(PWM_W), .PRESC_DIV(PRESC_DIV), .STEP_LOG2(STEP_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pwm(pwm), .period_start(period_start), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: t counts clock edges since reset release.
  int t;
  int sh_duty [N_CH];
  int act_duty [N_CH];
  int sh_mode, act_mode, k;
  bit sh_en, act_en;
  logic [N_CH-1:0] exp_pwm;
  int hi_cnt [N_CH];
  int shape_err [N_CH];
  int exp_hi [N_CH];
  int ps_err;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Effective duty from the mode rules, with k = periods since the mode was entered.
  function automatic int dutyEff(input int ch);
    int lvl;
    case (act_mode)
      0: return act_duty[ch];
      1: begin
        lvl = k % (2 * MAXV);
        if (lvl > MAXV) lvl = 2 * MAXV - lvl;
        return (act_duty[ch] * lvl) / PER;
      end
      2: return (((k >> STEP_LOG2) % 2) == 0) ? act_duty[ch] : 0;
      default: return (((k >> STEP_LOG2) % N_CH) == ch) ? MAXV : 0;
    endcase
  endfunction

  task automatic modelReset();
    t = 0; sh_mode = 0; act_mode = 0; k = 0; sh_en = 0; act_en = 0; ps_err = 0;
    exp_pwm = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      sh_duty[ch] = 0; act_duty[ch] = 0; hi_cnt[ch] = 0; shape_err[ch] = 0; exp_hi[ch] = 0;
    end
  endtask

  // One clock: drive an optional write, advance the model, sample at the falling edge.
  task automatic applyStimulus(input bit we, input int addr, input int data);
    bus.wr_en   = we;
    bus.wr_addr = 4'(addr);
    bus.wr_data = PWM_W'(data);
    @(posedge clk);
    for (int ch = 0; ch < N_CH; ch++)
      exp_pwm[ch] = act_en && ((t % PER) < dutyEff(ch));
    t++;
    if (t % PER == 0) begin
      if (sh_mode != act_mode) k = 0;
      else k++;
      act_mode = sh_mode;
      act_en   = sh_en;
      act_duty = sh_duty;
    end
    if (we) begin
      if (addr < N_CH) sh_duty[addr] = data % PER;
      else if (addr == 15) begin
        sh_mode = data % 4;
        sh_en   = ((data >> 2) & 1) == 1;
      end
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (period_start !== (t % PER == 0)) ps_err++;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (pwm[ch] !== exp_pwm[ch]) shape_err[ch]++;
      if (pwm[ch] === 1'b1) hi_cnt[ch]++;
    end
    if (t % PER == 0) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        checkOutput($sformatf("ch%0d_high", ch), hi_cnt[ch], exp_hi[ch]);
        checkOutput($sformatf("ch%0d_shape", ch), shape_err[ch], 0);
        hi_cnt[ch] = 0; shape_err[ch] = 0;
        exp_hi[ch] = act_en ? dutyEff(ch) : 0;
      end
      checkOutput("period_start", ps_err, 0);
      checkOutput("mode_o", mode_o, act_mode);
      ps_err = 0;
    end
  endtask

  task automatic wr(input int addr, input int data);
    applyStimulus(1'b1, addr, data);
  endtask

  task automatic nextPeriod();
    applyStimulus(1'b0, 0, 0);
    while (t % PER != 0) applyStimulus(1'b0, 0, 0);
  endtask

  task automatic runToPos(input int p);
    while (t % PER != p) applyStimulus(1'b0, 0, 0);
  endtask

  initial begin
    int sel, addr;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm", pwm, 0);
    checkOutput("reset_pstart", period_start, 0);
    checkOutput("reset_mode", mode_o, 0);
    rst_n = 1'b1;

    // Direct mode, channel 0 at quarter duty.
    wr(0, 8'h40); wr(15, 4);
    repeat (3) nextPeriod();

    // Duty extremes.
    wr(0, 0); wr(1, 8'hFF);
    repeat (2) nextPeriod();

    // Mid-period shadow write, then a write coincident with period_start.
    wr(0, 8'h40);
    nextPeriod();
    runToPos(8'h80);
    wr(0, 8'hC0);
    repeat (2) nextPeriod();
    wr(2, 8'h20);
    repeat (2) nextPeriod();

    // Test mode sweep.
    wr(15, 7);
    repeat (14) nextPeriod();

    // Breathe through the peak and back down.
    wr(1, 0); wr(2, 0); wr(0, 8'hFF); wr(15, 5);
    repeat (262) nextPeriod();

    // Random writes, including ignored addresses and enable off.
    for (int c = 0; c < 10 * PER; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        sel  = $urandom_range(0, 4);
        addr = (sel < 3) ? sel : ((sel == 3) ? 15 : $urandom_range(3, 14));
        wr(addr, $urandom_range(0, 255));
      end else begin
        applyStimulus(1'b0, 0, 0);
      end
    end
    nextPeriod();
    nextPeriod();

    // Asynchronous reset in the middle of a blink period.
    wr(15, 4);
    nextPeriod();
    wr(0, 8'h40); wr(15, 6);
    nextPeriod();
    runToPos(8'h30);
    checkOutput("pre_rst_pwm0", pwm[0], 1);
    checkOutput("pre_rst_mode", mode_o, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pwm", pwm, 0);
    checkOutput("async_rst_pstart", period_start, 0);
    checkOutput("async_rst_mode", mode_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (2) nextPeriod();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
